// File: rtl/ddfs_pkg.sv
// Shared constants and types for the quarter-wave DDFS.
package ddfs_pkg;

  // Default geometry: 24-bit phase, 1024-entry full wave, 12-bit signed output.
  localparam int DEF_PHASE_W = 24;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 12;

  // Quadrant bit roles: bit 0 mirrors the table index, bit 1 negates the sample.
  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_NEGATE_BIT = 1;

  localparam real QW_PI = 3.14159265358979323846;

  // Frequency word update policy.
  typedef enum logic {
    UPD_IMMEDIATE = 1'b0,
    UPD_AT_WRAP   = 1'b1
  } upd_mode_e;

  // Frequency update handshake state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } upd_state_e;

endpackage

// File: rtl/ddfs_qrom.sv
// Quarter-wave sine table, 2^(ADDR_W-2) unsigned entries of DATA_W-1 bits,
// one-cycle registered read. Entry k holds
// round((2^(DATA_W-1)-1) * sin(2*pi*(k+0.5)/2^ADDR_W)); the half-step offset keeps
// every entry strictly positive so the top can negate without overflow.
// The contents are elaborated from that formula; they are the same values that
// ROM_FILE carries for flows that prefer a memory init file.
module ddfs_qrom
  import ddfs_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter     ROM_FILE = "rom_qw.dat"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-3:0] addr,
  output logic [DATA_W-2:0] data
);

  localparam int QADDR_W = ADDR_W - 2;
  localparam int DEPTH   = 1 << QADDR_W;
  localparam int ENTRY_W = DATA_W - 1;

  // File name is informational only; see header.
  localparam bit unused_rom_file = |ROM_FILE;

  logic [ENTRY_W-1:0] rom_mem [DEPTH];
  logic [ENTRY_W-1:0] data_reg;

  function automatic logic [ENTRY_W-1:0] qw_entry(input int k);
    real amp;
    real ang;
    int  v;
    amp = real'((1 << (DATA_W - 1)) - 1);
    ang = 2.0 * QW_PI * (real'(k) + 0.5) / real'(1 << ADDR_W);
    v   = $rtoi(amp * $sin(ang) + 0.5);
    return v[ENTRY_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tbl
      assign rom_mem[gi] = qw_entry(gi);
    end
  endgenerate

  // Registered table read.
  always_ff @(posedge clk) begin
    if (!rst_n) data_reg <= '0;
    else        data_reg <= rom_mem[addr];
  end

  assign data = data_reg;

endmodule

// File: rtl/ddfs_qw.sv
// Direct digital frequency synthesiser with quarter-wave table.
// Phase accumulator -> phase offset -> quadrant fold -> table -> sign restore.
// Sample from the accumulator value present during an en=1 cycle appears on dout
// three cycles later. Frequency words go through a one-deep pending register and
// are applied either immediately or on the next accumulator wrap.
module ddfs_qw
  import ddfs_pkg::*;
#(
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter     ROM_FILE = "rom_qw.dat"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sync_clr,
  input  logic                     update_mode,
  input  logic [PHASE_W-1:0]       fcw_in,
  input  logic                     fcw_valid,
  output logic                     fcw_ready,
  input  logic [PHASE_W-1:0]       phase_off,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid
);

  localparam int QADDR_W = ADDR_W - 2;

  logic [PHASE_W-1:0] acc_reg;
  logic [PHASE_W-1:0] fcw_q_reg;
  logic [PHASE_W-1:0] pending_reg;
  upd_state_e         state_reg;
  logic               fcw_ready_reg;

  logic [PHASE_W:0]   acc_sum;
  logic               carry;
  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         quad;
  logic [QADDR_W-1:0] qidx;
  logic [QADDR_W-1:0] tbl_idx;
  logic               unused_phase_lo;

  logic [QADDR_W-1:0] tbl_idx_s1_reg;
  logic               neg_s1_reg;
  logic               vld_s1_reg;
  logic               neg_s2_reg;
  logic               vld_s2_reg;
  logic [DATA_W-2:0]  rom_data;
  logic signed [DATA_W-1:0] entry_ext;
  logic signed [DATA_W-1:0] dout_reg;
  logic               dout_valid_reg;

  // Carry is only meaningful on an advancing, non-clearing cycle.
  assign acc_sum = {1'b0, acc_reg} + {1'b0, fcw_q_reg};
  assign carry   = en & ~sync_clr & acc_sum[PHASE_W];

  // Phase decode: top ADDR_W bits form the full-wave address.
  assign phase   = acc_reg + phase_off;
  assign addr    = phase[PHASE_W-1 -: ADDR_W];
  assign quad    = addr[ADDR_W-1 -: 2];
  assign qidx    = addr[QADDR_W-1:0];
  // (2^QADDR_W - 1) - i is just the bitwise complement of i.
  assign tbl_idx = quad[QUAD_MIRROR_BIT] ? ~qidx : qidx;
  assign unused_phase_lo = ^phase[PHASE_W-ADDR_W-1:0];

  // Phase accumulator; sync_clr wins over en.
  always_ff @(posedge clk) begin
    if (!rst_n)        acc_reg <= '0;
    else if (sync_clr) acc_reg <= '0;
    else if (en)       acc_reg <= acc_sum[PHASE_W-1:0];
  end

  // Frequency word handshake: capture into pending, apply now or at wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= '0;
      fcw_q_reg     <= '0;
      fcw_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fcw_valid) begin
            pending_reg   <= fcw_in;
            state_reg     <= ST_PEND;
            fcw_ready_reg <= 1'b0;
          end
        end
        ST_PEND: begin
          if (sync_clr || (update_mode == UPD_IMMEDIATE) || carry) begin
            fcw_q_reg     <= pending_reg;
            state_reg     <= ST_IDLE;
            fcw_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          fcw_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: folded table index, sign flag and sample-issue flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_idx_s1_reg <= '0;
      neg_s1_reg     <= 1'b0;
      vld_s1_reg     <= 1'b0;
    end else begin
      tbl_idx_s1_reg <= tbl_idx;
      neg_s1_reg     <= quad[QUAD_NEGATE_BIT];
      vld_s1_reg     <= en;
    end
  end

  ddfs_qrom #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ROM_FILE (ROM_FILE)
  ) u_qrom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (tbl_idx_s1_reg),
    .data  (rom_data)
  );

  // Stage 2: sign and valid travel alongside the registered table read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_s2_reg <= 1'b0;
      vld_s2_reg <= 1'b0;
    end else begin
      neg_s2_reg <= neg_s1_reg;
      vld_s2_reg <= vld_s1_reg;
    end
  end

  assign entry_ext = signed'({1'b0, rom_data});

  // Stage 3: restore sign; dout only moves when a sample is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= vld_s2_reg;
      if (vld_s2_reg) dout_reg <= neg_s2_reg ? -entry_ext : entry_ext;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign fcw_ready  = fcw_ready_reg;

endmodule

// File: doc/ddfs_qw.md
DDFS_QW -- requirements
Module: ddfs_qw

Interface
REQ-001 SHALL have parameter PHASE_W, default 24: phase accumulator and frequency word width.
REQ-002 SHALL have parameter ADDR_W, default 10: full-wave table address width, ADDR_W >= 3, ADDR_W < PHASE_W.
REQ-003 SHALL have parameter DATA_W, default 12: signed output width.
REQ-004 SHALL have parameter ROM_FILE, default "rom_qw.dat": binary init file for the quarter-wave table.
REQ-005 Port: clk  input  1  sole clock, all state on rising edge.
REQ-006 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-007 Port: en  input  1  advance accumulator and issue a sample this cycle.
REQ-008 Port: sync_clr  input  1  zero phase accumulator.
REQ-009 Port: update_mode  input  1  0 = immediate frequency update, 1 = update at phase wrap.
REQ-010 Port: fcw_in  input  PHASE_W  new frequency control word.
REQ-011 Port: fcw_valid  input  1  fcw_in offered.
REQ-012 Port: fcw_ready  output  1  block can accept fcw_in.
REQ-013 Port: phase_off  input  PHASE_W  phase offset added after the accumulator, unsigned mod 2^PHASE_W.
REQ-014 Port: dout  output  DATA_W  signed sine sample.
REQ-015 Port: dout_valid  output  1  dout carries a new sample.

Function
REQ-016 Accumulator acc, PHASE_W bits: when en=1, acc <= acc + fcw_q mod 2^PHASE_W; carry = carry-out of that sum; when en=0, acc and carry are held/0.
REQ-017 sync_clr=1 SHALL set acc to 0 next cycle regardless of en; no carry is reported that cycle.
REQ-018 Phase p = acc + phase_off mod 2^PHASE_W; address a = p[PHASE_W-1 : PHASE_W-ADDR_W]; quadrant q = a[ADDR_W-1:ADDR_W-2]; index i = a[ADDR_W-3:0].
REQ-019 Table index SHALL be i when q[0]=0, else (2^(ADDR_W-2)-1) - i.
REQ-020 Table entry k SHALL equal round((2^(DATA_W-1)-1) * sin(2*pi*(k+0.5)/2^ADDR_W)); all entries positive, so negation never overflows.
REQ-021 dout SHALL be +entry when q[1]=0, -entry (two's complement) when q[1]=1.
REQ-022 Pipeline: stage1 registers table index and q[1]; stage2 registers table read; stage3 registers signed dout. The sample from acc value at an en=1 edge t appears on dout with dout_valid=1 at edge t+3.
REQ-023 dout_valid SHALL be en delayed 3 cycles; dout SHALL hold its last value while dout_valid=0.
REQ-024 Update FSM states: IDLE (fcw_ready=1), PEND (fcw_ready=0, pending word held).
REQ-025 IDLE, fcw_valid=1: capture fcw_in into pending, go to PEND.
REQ-026 PEND, update_mode=0: fcw_q <= pending on the next edge, go to IDLE.
REQ-027 PEND, update_mode=1: fcw_q <= pending on the edge where carry=1 (en=1), go to IDLE; otherwise stay. The sum producing the carry uses the old fcw_q.
REQ-028 PEND with sync_clr=1 SHALL apply pending on that edge in either mode, so frequency and phase restart together.
REQ-029 fcw_valid while fcw_ready=0 SHALL be ignored; the word is not captured.
REQ-030 Change of update_mode while in PEND SHALL take effect on the following edge.

Reset
REQ-031 rst_n=0 at an edge: acc=0, fcw_q=0, pending=0, FSM=IDLE, pipeline registers=0, dout=0, dout_valid=0, fcw_ready=1.
REQ-032 Reset mid-operation SHALL discard any pending word and all in-flight samples; the first post-reset valid sample appears 3 cycles after the first en=1 edge.

Structure
REQ-033 Shared package ddfs_pkg SHALL hold default PHASE_W/ADDR_W/DATA_W constants, the quadrant mirror/negate bit positions, the update-mode encoding and the FSM state type.
REQ-034 Quarter-wave table SHALL be sub-module ddfs_qrom (registered read, 2^(ADDR_W-2) x (DATA_W-1) unsigned, loaded from ROM_FILE).

Verification
REQ-035 Defaults, fcw=0, en=1 -> dout constant 6 from cycle 3, dout_valid=1.
REQ-036 fcw=2^22, en=1 -> dout repeats 6, 2047, -6, -2047; period 4 samples.
REQ-037 fcw=2^22, phase_off=2^23 -> dout repeats -6, -2047, 6, 2047.
REQ-038 fcw=2^22 running, update_mode=1, offer fcw_in=2^21 at acc=0x400000 -> fcw_ready low until the edge where acc wraps 0xC00000->0; thereafter acc steps by 0x200000; no step truncated.
REQ-039 update_mode=0, offer 2^14 -> fcw_q updated next edge; then consecutive addresses, period 1024 samples; a second fcw_valid during PEND is not captured.
REQ-040 en toggled 1,0,1 and rst_n pulsed low mid-stream -> dout_valid mirrors en delayed 3; after reset dout=0, fcw_ready=1, acc restarts from 0.
